rom_stream_reader: RTL and testbench



---
 rtl/rom_stream_reader_pkg.sv | 25 ++
 rtl/rom_stream_reader_if.sv | 38 +++
 rtl/rom_rd_skid_fifo.sv | 52 +++++
 rtl/rom_stream_reader.sv | 129 ++++++++++++
 tb/tb_rom_stream_reader.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared types and constants for the ROM stream reader.
// Holds the FSM encoding and the buffer credit check.
package rom_reader_pkg;

    localparam int AW_DEF    = 8;
    localparam int DW_DEF    = 8;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Words already owned (buffered + in flight) minus this cycle's pop
    // must leave room for one more.
    function automatic logic credit_ok(
        input logic [1:0] cnt,
        input logic       inflight,
        input logic       pop
    );
        return ({1'b0, cnt} + {2'b0, inflight}) <= (3'd1 + {2'b0, pop});
    endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// ROM read bus and output stream bundles.
// Master side drives the request / the stream.
interface rom_rd_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] rom_address;
    logic          rom_read_en;
    logic          rom_ce;
    logic [DW-1:0] rom_data;

    modport master (
        output rom_address, rom_read_en, rom_ce,
        input  rom_data
    );
    modport slave (
        input  rom_address, rom_read_en, rom_ce,
        output rom_data
    );
endinterface

interface rom_stream_if #(
    parameter int DW = 8
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output out_data, out_valid, out_last,
        input  out_ready
    );
    modport slave (
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/rom_rd_skid_fifo.sv
// Two-entry FIFO of {last, data} between ROM capture and stream output.
// Flush empties it in one cycle and wins over push/pop.
module rom_rd_skid_fifo
    import rom_reader_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [BUF_DEPTH];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (flush_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Sweeps a ROM address window and streams the words out with a last marker.
// Reads are credit-limited so the 2-entry buffer never overflows.
module rom_stream_reader
    import rom_reader_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW-1:0]   start_addr,
    input  logic [AW:0]     len,
    input  logic            abort,
    rom_rd_if.master        rom,
    rom_stream_if.master    out,
    output logic            busy,
    output logic            done
);

    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   remain_q, remain_d;
    logic          ce_q, ce_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          ilast_q, ilast_d;
    logic          done_q, done_d;
    logic          flush;
    logic          pop;
    logic [1:0]    count;
    logic [DW:0]   head;

    assign pop = out.out_valid && out.out_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        ce_d     = 1'b0;
        raddr_d  = '0;
        ilast_d  = 1'b0;
        done_d   = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        addr_d   = start_addr;
                        remain_d = len;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (credit_ok(count, ce_q, pop)) begin
                    ce_d     = 1'b1;
                    raddr_d  = addr_q;
                    addr_d   = addr_q + AW'(1);
                    remain_d = remain_q - LEN_ONE;
                    ilast_d  = (remain_q == LEN_ONE);
                    if (remain_q == LEN_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                    flush   = 1'b1;
                end else if (pop && out.out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            ce_q     <= 1'b0;
            raddr_q  <= '0;
            ilast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            ce_q     <= ce_d;
            raddr_q  <= raddr_d;
            ilast_q  <= ilast_d;
            done_q   <= done_d;
        end
    end

    // An abort also drops the read still in flight.
    rom_rd_skid_fifo #(
        .W (DW + 1)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .push_i      (ce_q && !flush),
        .push_data_i ({ilast_q, rom.rom_data}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign rom.rom_address = raddr_q;
    assign rom.rom_ce      = ce_q;
    assign rom.rom_read_en = ce_q;
    assign out.out_valid   = (count != 2'd0);
    assign out.out_data    = head[DW-1:0];
    assign out.out_last    = out.out_valid && head[DW];
    assign busy            = (state_q != IDLE);
    assign done            = done_q;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: directed vector table, corner sequences
// and random windows checked against a queue-based reference model.
module tb_rom_stream_reader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] start_addr;
    logic [8:0] len;
    logic [7:0] rom_mem [256];

    int total = 0;
    int bad   = 0;

    rom_rd_if #(.AW(8), .DW(8)) rif ();
    rom_stream_if #(.DW(8)) sif ();

    assign rif.rom_data = (rif.rom_ce && rif.rom_read_en) ?
                          rom_mem[rif.rom_address] : 8'h00;

    rom_stream_reader #(.AW(8), .DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .abort      (abort),
        .rom        (rif),
        .out        (sif),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] addr;
        logic [8:0] len;
        int         mode;
        bit         spur;
        int         words;
        logic [7:0] first;
        logic [7:0] lastw;
        int         lat;
        int         span;
        logic       busy0;
    } vec_t;

    vec_t tv [7];

    logic [8:0] got_q [$];
    logic [7:0] iss_q [$];
    int   n_iss, n_pop, first_ce, last_ce, cyc_g;
    logic prev_stall, prev_last;
    logic [7:0] prev_data;
    int   st_lat, st_dcnt;
    logic st_busy0, st_busy_done;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            1: return (c >= 6 && c <= 10) ? 1'b0 : (c % 3 == 0);
            2: return $urandom_range(0, 3) != 0;
            3: return $urandom_range(0, 1) == 1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic mon_reset();
        got_q.delete();
        iss_q.delete();
        n_iss      = 0;
        n_pop      = 0;
        first_ce   = -1;
        last_ce    = -1;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        prev_data  = 8'h00;
    endtask

    // Called once per cycle at the falling edge.
    task automatic mon();
        logic pop;
        pop = sif.out_valid && sif.out_ready;
        if (rif.rom_ce) begin
            iss_q.push_back(rif.rom_address);
            if (first_ce < 0) first_ce = cyc_g;
            last_ce = cyc_g;
            total++;
            if (rif.rom_read_en !== 1'b1 ||
                (n_iss - n_pop - (pop ? 1 : 0)) > 1) begin
                bad++;
                $display("FAIL credit: cyc %0d owned %0d re %b",
                         cyc_g, n_iss - n_pop, rif.rom_read_en);
            end
        end
        if (prev_stall) begin
            total++;
            if (sif.out_valid !== 1'b1 || sif.out_data !== prev_data ||
                sif.out_last !== prev_last) begin
                bad++;
                $display("FAIL hold: got v%b %h l%b want v1 %h l%b",
                         sif.out_valid, sif.out_data, sif.out_last,
                         prev_data, prev_last);
            end
        end
        if (pop) got_q.push_back({sif.out_last, sif.out_data});
        if (rif.rom_ce) n_iss++;
        if (pop) n_pop++;
        prev_stall = sif.out_valid && !sif.out_ready;
        prev_data  = sif.out_data;
        prev_last  = sif.out_last;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [8:0] n,
                          input int mode, input bit spur);
        logic [7:0] ea [$];
        logic [8:0] ed [$];
        logic [7:0] ad;
        int post;
        int budget;
        mon_reset();
        for (int i = 0; i < int'(n); i++) begin
            ad = 8'(int'(a) + i);
            ea.push_back(ad);
            ed.push_back({i == int'(n) - 1, rom_mem[ad]});
        end
        budget = 4 * int'(n) + 40;
        st_lat = -1;
        st_dcnt = 0;
        st_busy0 = 1'b0;
        st_busy_done = 1'b0;
        post = -1;
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = a;
        len = n;
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc_g = 0;
        while (cyc_g < budget) begin
            sif.out_ready = rdy(mode, cyc_g);
            if (spur && cyc_g == 3) begin
                start = 1'b1;
                start_addr = 8'h99;
                len = 9'd3;
            end
            @(negedge clk);
            mon();
            if (cyc_g == 0) st_busy0 = busy;
            if (sif.out_valid && st_lat < 0) st_lat = cyc_g;
            if (done) begin
                st_dcnt++;
                if (busy) st_busy_done = 1'b1;
                if (post < 0) post = cyc_g;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (post >= 0 && cyc_g >= post + 3) break;
            cyc_g++;
        end
        check("op_finished", 32'(post >= 0), 32'd1);
        check("word_count", got_q.size(), ed.size());
        for (int i = 0; i < ed.size() && i < got_q.size(); i++)
            check($sformatf("word[%0d]", i), 32'(got_q[i]), 32'(ed[i]));
        check("issue_count", iss_q.size(), ea.size());
        for (int i = 0; i < ea.size() && i < iss_q.size(); i++)
            check($sformatf("addr[%0d]", i), 32'(iss_q[i]), 32'(ea[i]));
        check("done_pulses", st_dcnt, 1);
        check("busy_at_done", 32'(st_busy_done), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ce"},    32'(rif.rom_ce), 0);
        check({tag, "_re"},    32'(rif.rom_read_en), 0);
        check({tag, "_addr"},  32'(rif.rom_address), 0);
        check({tag, "_valid"}, 32'(sif.out_valid), 0);
        check({tag, "_data"},  32'(sif.out_data), 0);
        check({tag, "_last"},  32'(sif.out_last), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [8:0] rn;
        logic flag;

        tv[0] = '{8'h10, 9'd4,   0, 1'b0, 4,   8'h10, 8'h13, 2, 4,   1'b1};
        tv[1] = '{8'hFE, 9'd4,   0, 1'b0, 4,   8'hFE, 8'h01, 2, 4,   1'b1};
        tv[2] = '{8'h30, 9'd8,   1, 1'b0, 8,   8'h30, 8'h37, 2, -1,  1'b1};
        tv[3] = '{8'h40, 9'd0,   0, 1'b0, 0,   8'h00, 8'h00, -1, 0,  1'b0};
        tv[4] = '{8'h00, 9'd256, 0, 1'b0, 256, 8'h00, 8'hFF, 2, 256, 1'b1};
        tv[5] = '{8'hF0, 9'd1,   0, 1'b0, 1,   8'hF0, 8'hF0, 2, 1,   1'b1};
        tv[6] = '{8'h70, 9'd6,   0, 1'b1, 6,   8'h70, 8'h75, 2, 6,   1'b1};

        for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_addr = 8'h00;
        len = 9'd0;
        sif.out_ready = 1'b1;
        cyc_g = 0;
        mon_reset();
        #3;
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_op(tv[v].addr, tv[v].len, tv[v].mode, tv[v].spur);
            check($sformatf("v%0d_words", v), got_q.size(), tv[v].words);
            if (got_q.size() > 0 && tv[v].words > 0) begin
                check($sformatf("v%0d_first", v), 32'(got_q[0][7:0]),
                      32'(tv[v].first));
                check($sformatf("v%0d_lastw", v), 32'(got_q[$]), 
                      32'({1'b1, tv[v].lastw}));
            end
            check($sformatf("v%0d_lat", v), st_lat, tv[v].lat);
            if (tv[v].span >= 0)
                check($sformatf("v%0d_span", v),
                      (first_ce < 0) ? 0 : last_ce - first_ce + 1,
                      tv[v].span);
            check($sformatf("v%0d_busy0", v), 32'(st_busy0),
                  32'(tv[v].busy0));
        end

        // Abort after the third transfer of a 16-word window.
        mon_reset();
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = 8'h50;
        len = 9'd16;
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc_g = 0;
        while (got_q.size() < 3 && cyc_g < 40) begin
            @(negedge clk);
            mon();
            @(posedge clk); #1;
            cyc_g++;
        end
        check("abort_reached3", got_q.size(), 3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_ce", 32'(rif.rom_ce), 0);
        check("abort_valid", 32'(sif.out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || rif.rom_ce || sif.out_valid) flag = 1'b1;
        end
        check("abort_quiet", 32'(flag), 0);
        if (got_q.size() >= 3)
            check("abort_w2", 32'(got_q[2]), 32'h052);
        run_op(8'h20, 9'd2, 0, 1'b0);
        check("after_abort_w0", 32'(got_q.size() > 0 ? got_q[0] : 9'h1ff),
              32'h020);

        // Start together with abort in IDLE is dropped.
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        start_addr = 8'h33;
        len = 9'd5;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || rif.rom_ce) flag = 1'b1;
        end
        check("start_abort_idle", 32'(flag), 0);

        // Asynchronous reset in the middle of a read sweep.
        @(posedge clk); #1;
        start = 1'b1;
        start_addr = 8'h60;
        len = 9'd16;
        sif.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_reset_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 0);

        // Random windows over random ROM contents.
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
        for (int r = 0; r < 25; r++) begin
            ra = 8'($urandom);
            rn = ($urandom_range(0, 9) == 0) ? 9'd0 :
                 9'($urandom_range(1, 24));
            run_op(ra, rn, $urandom_range(2, 3),
                   (rn >= 9'd4) && ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
